// File: rtl/vga_passthru_sampler.sv
// Raspberry Pi VGA passthrough: synchronised sync/video pins, strobe-based sampling
// and colour-mode mapping onto registered RGB DAC bits with matched sync delay.
module vga_passthru_sampler #(
    parameter int COLOR_W         = 3,
    parameter int DIV_W           = 15,
    parameter int SEL_W           = 4,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [8:0]         key,
    input  logic               rpi_hsync,
    input  logic               rpi_vsync,
    input  logic               analog_in,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic               h_sync,
    output logic               v_sync
);

    localparam int   C    = COLOR_W;
    localparam int   SR_W = 3 * COLOR_W;
    localparam logic IDLE = (SYNC_ACTIVE_LOW != 0);
    localparam logic ACT  = !IDLE;

    localparam logic [SEL_W-1:0] SEL_ALL = '1;

    localparam logic [2:0] M_MONO   = 3'b000;
    localparam logic [2:0] M_RED    = 3'b001;
    localparam logic [2:0] M_GREEN  = 3'b010;
    localparam logic [2:0] M_BLUE   = 3'b011;
    localparam logic [2:0] M_SHIFT  = 3'b100;
    localparam logic [2:0] M_INV    = 3'b101;
    localparam logic [2:0] M_FREEZE = 3'b110;

    logic [1:0]       hs_sync, vs_sync, an_sync;
    logic [8:0]       key_m, key_s;
    logic             hs_d1, vs_d1;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] mask;
    logic [SEL_W-1:0] sel;
    logic [2:0]       mode;
    logic             tick;
    logic             s_bit;
    logic [SR_W-1:0]  sr;
    logic             blank;
    logic [C-1:0]     r_nx, g_nx, b_nx;
    logic             unused_key;

    // Sync-line flops idle at the inactive level so reset never looks like a pulse
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hs_sync <= {2{IDLE}};
            vs_sync <= {2{IDLE}};
            an_sync <= '0;
            key_m   <= '0;
            key_s   <= '0;
            hs_d1   <= IDLE;
            vs_d1   <= IDLE;
            h_sync  <= IDLE;
            v_sync  <= IDLE;
        end else begin
            hs_sync <= {hs_sync[0], rpi_hsync};
            vs_sync <= {vs_sync[0], rpi_vsync};
            an_sync <= {an_sync[0], analog_in};
            key_m   <= key;
            key_s   <= key_m;
            hs_d1   <= hs_sync[1];
            vs_d1   <= vs_sync[1];
            h_sync  <= hs_d1;
            v_sync  <= vs_d1;
        end
    end

    assign sel        = key_s[4+SEL_W:5];
    assign mode       = key_s[2:0];
    assign unused_key = key_s[3];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else        div <= div + 1'b1;
    end

    // Low (DIV_W - sel) bits of the divider must be all ones to strobe
    always_comb begin
        mask = '0;
        for (int i = 0; i < DIV_W; i++) begin
            mask[i] = (i <= (DIV_W - 1 - int'(sel)));
        end
    end

    assign tick = (sel == SEL_ALL) || ((div & mask) == mask);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s_bit <= 1'b0;
            sr    <= '0;
        end else if (tick && (mode != M_FREEZE)) begin
            s_bit <= an_sync[1];
            sr    <= {sr[SR_W-2:0], an_sync[1]};
        end
    end

    // hs_d1/vs_d1 feed h_sync/v_sync on the same edge as the colour register
    assign blank = key_s[4] && ((hs_d1 == ACT) || (vs_d1 == ACT));

    always_comb begin
        r_nx = '0;
        g_nx = '0;
        b_nx = '0;
        case (mode)
            M_RED:   r_nx = {C{s_bit}};
            M_GREEN: g_nx = {C{s_bit}};
            M_BLUE:  b_nx = {C{s_bit}};
            M_SHIFT, M_FREEZE: begin
                r_nx = sr[3*C-1:2*C];
                g_nx = sr[2*C-1:C];
                b_nx = sr[C-1:0];
            end
            M_INV: begin
                r_nx = {C{~s_bit}};
                g_nx = {C{~s_bit}};
                b_nx = {C{~s_bit}};
            end
            default: begin
                r_nx = {C{s_bit}};
                g_nx = {C{s_bit}};
                b_nx = {C{s_bit}};
            end
        endcase
        if (blank) begin
            r_nx = '0;
            g_nx = '0;
            b_nx = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            g_out <= '0;
            b_out <= '0;
        end else begin
            r_out <= r_nx;
            g_out <= g_nx;
            b_out <= b_nx;
        end
    end

endmodule

// File: tb/tb_vga_passthru_sampler.sv
// Directed self-checking bench for vga_passthru_sampler (default parameters).
module tb_vga_passthru_sampler;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] key = '0;
    logic       rpi_hsync = 1'b0;
    logic       rpi_vsync = 1'b0;
    logic       analog_in = 1'b1;
    logic [2:0] r_out, g_out, b_out;
    logic       h_sync, v_sync;

    int vectors = 0;
    int errors = 0;

    vga_passthru_sampler dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .key       (key),
        .rpi_hsync (rpi_hsync),
        .rpi_vsync (rpi_vsync),
        .analog_in (analog_in),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .h_sync    (h_sync),
        .v_sync    (v_sync)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #4;
        vectors++;
        if ({r_out, g_out, b_out} !== 9'b0) begin
            errors++;
            $display("FAIL reset_rgb got %b want %b", {r_out, g_out, b_out}, 9'b0);
        end
        vectors++;
        if ({h_sync, v_sync} !== 2'b11) begin
            errors++;
            $display("FAIL reset_sync got %b want 11", {h_sync, v_sync});
        end
        step(3);
        rst_n = 1'b1;
        step(2);
        vectors++;
        if ({h_sync, v_sync, r_out, g_out, b_out} !== 11'b11_000000000) begin
            errors++;
            $display("FAIL post_release_hold got %b want %b",
                     {h_sync, v_sync, r_out, g_out, b_out}, 11'b11_000000000);
        end
        step(2);
        vectors++;
        if ({h_sync, v_sync} !== 2'b00) begin
            errors++;
            $display("FAIL post_release_sync_prop got %b want 00", {h_sync, v_sync});
        end
        rpi_hsync = 1'b1;
        rpi_vsync = 1'b1;
        step(5);
    endtask

    task automatic test_latency;
        key = 9'b1111_0_0_000;
        analog_in = 1'b0;
        step(6);
        vectors++;
        if ({r_out, g_out, b_out} !== 9'b0) begin
            errors++;
            $display("FAIL latency_pre got %b want %b", {r_out, g_out, b_out}, 9'b0);
        end
        analog_in = 1'b1;
        step(3);
        vectors++;
        if ({r_out, g_out, b_out} !== 9'b0) begin
            errors++;
            $display("FAIL latency_edge3 got %b want %b", {r_out, g_out, b_out}, 9'b0);
        end
        step(1);
        vectors++;
        if ({r_out, g_out, b_out} !== 9'h1ff) begin
            errors++;
            $display("FAIL latency_edge4 got %b want %b", {r_out, g_out, b_out}, 9'h1ff);
        end
    endtask

    task automatic test_hsync_delay;
        rpi_hsync = 1'b0;
        step(1);
        rpi_hsync = 1'b1;
        step(2);
        vectors++;
        if (h_sync !== 1'b1) begin
            errors++;
            $display("FAIL hsync_edge3 got %b want 1", h_sync);
        end
        step(1);
        vectors++;
        if (h_sync !== 1'b0) begin
            errors++;
            $display("FAIL hsync_edge4 got %b want 0", h_sync);
        end
        step(1);
        vectors++;
        if (h_sync !== 1'b1) begin
            errors++;
            $display("FAIL hsync_edge5 got %b want 1", h_sync);
        end
    endtask

    task automatic test_rate_select;
        int         changes;
        logic [2:0] prev;
        key = 9'b1110_0_0_000;
        changes = 0;
        prev = r_out;
        for (int i = 0; i < 30; i++) begin
            analog_in = ~analog_in;
            step(1);
            if (i >= 8 && r_out !== prev) changes++;
            prev = r_out;
        end
        vectors++;
        if (changes !== 0) begin
            errors++;
            $display("FAIL rate_sel14_changes got %0d want 0", changes);
        end
        key = 9'b1111_0_0_000;
        changes = 0;
        for (int i = 0; i < 30; i++) begin
            analog_in = ~analog_in;
            step(1);
            if (i >= 8 && r_out !== prev) changes++;
            prev = r_out;
        end
        vectors++;
        if (changes !== 22) begin
            errors++;
            $display("FAIL rate_sel15_changes got %0d want 22", changes);
        end
    endtask

    task automatic test_shift_freeze;
        logic [8:0] pat;
        pat = 9'b101_100_111;
        key = 9'b1111_0_0_100;
        step(3);
        for (int i = 0; i < 9; i++) begin
            analog_in = pat[8-i];
            step(1);
        end
        key = 9'b1111_0_0_110;
        step(3);
        vectors++;
        if ({r_out, g_out, b_out} !== pat) begin
            errors++;
            $display("FAIL shift_pattern got %b want %b", {r_out, g_out, b_out}, pat);
        end
        for (int i = 0; i < 10; i++) begin
            analog_in = ~analog_in;
            step(1);
        end
        vectors++;
        if ({r_out, g_out, b_out} !== pat) begin
            errors++;
            $display("FAIL freeze_hold got %b want %b", {r_out, g_out, b_out}, pat);
        end
    endtask

    task automatic test_blank;
        logic [8:0] pat;
        logic       vs_exp;
        logic [8:0] rgb_exp;
        pat = 9'b101_100_111;
        key = 9'b1111_1_0_110;
        step(3);
        vectors++;
        if ({r_out, g_out, b_out} !== pat) begin
            errors++;
            $display("FAIL blank_idle got %b want %b", {r_out, g_out, b_out}, pat);
        end
        rpi_vsync = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            vs_exp = (k >= 4 && k <= 13) ? 1'b0 : 1'b1;
            rgb_exp = vs_exp ? pat : 9'b0;
            vectors++;
            if ({v_sync, r_out, g_out, b_out} !== {vs_exp, rgb_exp}) begin
                errors++;
                $display("FAIL blank_cycle%0d got %b want %b", k,
                         {v_sync, r_out, g_out, b_out}, {vs_exp, rgb_exp});
            end
            if (k == 10) rpi_vsync = 1'b1;
        end
    endtask

    task automatic test_color_modes;
        logic [2:0] modes [6];
        logic [8:0] exps  [6];
        modes = '{3'b001, 3'b101, 3'b111, 3'b010, 3'b011, 3'b000};
        exps  = '{9'b111_000_000, 9'b000_000_000, 9'b111_111_111,
                  9'b000_111_000, 9'b000_000_111, 9'b111_111_111};
        analog_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            key = {4'b1111, 1'b0, 1'b0, modes[i]};
            step(5);
            vectors++;
            if ({r_out, g_out, b_out} !== exps[i]) begin
                errors++;
                $display("FAIL color_mode_%b got %b want %b", modes[i],
                         {r_out, g_out, b_out}, exps[i]);
            end
        end
    endtask

    task automatic test_slow_rate;
        int         changes;
        logic [8:0] prev;
        analog_in = 1'b0;
        key = 9'b0000_0_0_000;
        changes = 0;
        prev = {r_out, g_out, b_out};
        for (int i = 0; i < 32776; i++) begin
            step(1);
            if ({r_out, g_out, b_out} !== prev) changes++;
            prev = {r_out, g_out, b_out};
        end
        vectors++;
        if (changes !== 1 || prev !== 9'b0) begin
            errors++;
            $display("FAIL sel0_single_tick got %0d changes final %b want 1 changes final 0",
                     changes, prev);
        end
        changes = 0;
        for (int i = 0; i < 32768; i++) begin
            if (i % 5 == 0) analog_in = ~analog_in;
            step(1);
            if ({r_out, g_out, b_out} !== prev) changes++;
            prev = {r_out, g_out, b_out};
        end
        vectors++;
        if (changes > 1) begin
            errors++;
            $display("FAIL sel0_max_one_change got %0d want <=1", changes);
        end
    endtask

    task automatic test_mid_reset;
        analog_in = 1'b1;
        rpi_hsync = 1'b0;
        key = 9'b1111_0_0_000;
        step(6);
        vectors++;
        if ({h_sync, r_out, g_out, b_out} !== 10'b0_111111111) begin
            errors++;
            $display("FAIL mid_reset_pre got %b want %b",
                     {h_sync, r_out, g_out, b_out}, 10'b0_111111111);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({h_sync, v_sync, r_out, g_out, b_out} !== 11'b11_000000000) begin
            errors++;
            $display("FAIL mid_reset_async got %b want %b",
                     {h_sync, v_sync, r_out, g_out, b_out}, 11'b11_000000000);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_hsync_delay();
        test_rate_select();
        test_shift_freeze();
        test_blank();
        test_color_modes();
        test_slow_rate();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
